pipe_stage_skid: RTL
====================

Name: pipe_stage_skid

Overview:
- Parametrised pipeline-stage register; generalises the fixed ID/EX latch into a reusable stage for any inter-stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries an opaque payload bus with valid/ready flow control, a 2-entry skid buffer (full throughput, registered up_ready), a flush input that converts contents to bubbles, and a saturating stall-cycle counter.

Parameters:
- DATA_W, 64, payload width in bits; minimum 1.
- BUBBLE, 0 (DATA_W bits), payload value driven while the stage is empty, after reset and after flush (e.g. the NOP encoding of aluop/alusel).
- CNT_W, 16, stall-counter width in bits; minimum 1.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- up_valid  in  1  upstream offers a payload this cycle.
- up_payload  in  DATA_W  upstream payload.
- up_ready  out  1  stage accepts a payload; a transfer occurs when up_valid && up_ready.
- down_valid  out  1  the stage holds a valid payload.
- down_payload  out  DATA_W  head payload; equals BUBBLE when down_valid=0.
- down_ready  in  1  downstream consumes; a transfer occurs when down_valid && down_ready.
- flush  in  1  discard all contents at the next edge.
- occupancy  out  2  number of held entries (0..2).
- stall_cnt  out  CNT_W  saturating count of cycles with down_valid && !down_ready.
- stall_cnt_clr  in  1  clear stall_cnt.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Storage: main register (head, drives down_*) and skid register. State derives from occupancy: EMPTY (0), ONE (main only), FULL (main + skid).
- up_ready = (occupancy != 2), driven from a register. No combinational path from down_ready to up_ready.
- down_valid = (occupancy != 0). down_payload = main when valid, else BUBBLE. Both are registered outputs.
- Latency: a payload accepted in cycle N appears on down_* in cycle N+1 when the stage was EMPTY, or when it was ONE and the head is consumed in N.
- Transitions per edge (acc = upstream transfer, con = downstream transfer):
  - EMPTY: acc -> ONE (main <= up_payload).
  - ONE, acc && con: stay ONE, main <= up_payload.
  - ONE, acc && !con: -> FULL, skid <= up_payload.
  - ONE, !acc && con: -> EMPTY.
  - FULL, con: -> ONE, main <= skid. No acceptance is possible because up_ready=0.
  - FULL, !con: hold.
- Ordering: strict FIFO. No payload is ever duplicated or dropped except by flush or rst.
- Payload hold: while down_valid && !down_ready, down_payload is stable.
- flush: at the next edge occupancy <= 0, down_valid <= 0, down_payload <= BUBBLE, up_ready <= 1.
  - Any upstream or downstream transfer in the flush cycle is discarded and counts as not taken. Upstream must re-present the payload if needed.
  - flush does not affect stall_cnt.
- rst: same effect as flush, plus stall_cnt <= 0. Takes priority over flush and all transfers, including mid-operation when FULL.
- Reset values: up_ready=1, down_valid=0, down_payload=BUBBLE, occupancy=0, stall_cnt=0. The skid register is cleared to BUBBLE.
- stall_cnt:
  - Increments by 1 on each edge where down_valid && !down_ready in the preceding cycle.
  - Saturates at 2^CNT_W-1 and does not wrap.
  - stall_cnt_clr sets it to 0 and wins over an increment in the same cycle.
- Inputs with up_valid=0 are ignored regardless of up_payload. down_ready with down_valid=0 has no effect.

Test Plan:
- Reset mid-FULL: fill with 0xA1, 0xA2, assert rst for 1 cycle -> next cycle down_valid=0, down_payload=BUBBLE, occupancy=0, up_ready=1, stall_cnt=0.
- Streaming: up_valid=1 with 0x01..0x08 on consecutive cycles, down_ready=1 -> down_payload shows 0x01..0x08 on consecutive cycles starting 1 cycle later; occupancy stays 1; stall_cnt=0.
- Backpressure/skid: send 0x10, 0x11, 0x12 back-to-back, down_ready=0 -> up_ready drops after 0x11 is accepted, 0x12 is not taken, occupancy=2, down_payload stays 0x10. Raise down_ready -> output order 0x10, 0x11, then 0x12 once re-accepted.
- Flush with simultaneous transfers: occupancy=2 (0x20, 0x21), assert flush with up_valid=1 (0x22) and down_ready=1 -> next cycle occupancy=0, down_payload=BUBBLE; 0x22 never appears on down_*.
- Counter: CNT_W=3, hold down_valid=1 with down_ready=0 for 10 cycles -> stall_cnt reads 7 and holds. Assert stall_cnt_clr while still stalling -> 0 next cycle, then 1.
- Random: random up_valid/down_ready/flush over 10k cycles with DATA_W=1 and DATA_W=97 -> output matches a reference FIFO model (flush clears the model) and payload is stable under stall.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// -----------------------------------------------------------------------------
// pipe_stage_skid
//
// Reusable pipeline-stage register for any inter-stage boundary. It carries an
// opaque payload with valid/ready flow control through a 2-entry skid buffer,
// so a full-rate stream can pass without a combinational ready path. A flush
// turns the contents into bubbles, and a saturating counter records stall
// cycles at the output.
//
// Ports
//   clk            clock, all state updates on the rising edge
//   rst            synchronous active-high reset
//   up_valid       upstream offers up_payload this cycle
//   up_payload     upstream payload (DATA_W bits)
//   up_ready       stage can accept; registered, high unless both entries used
//   down_valid     head entry is valid; registered
//   down_payload   head payload, BUBBLE while the stage is empty; registered
//   down_ready     downstream consumes the head this cycle
//   flush          discard all contents at the next edge
//   occupancy      number of held entries, 0..2
//   stall_cnt      saturating count of cycles with down_valid && !down_ready
//   stall_cnt_clr  clear stall_cnt; wins over a same-cycle increment
// -----------------------------------------------------------------------------
module pipe_stage_skid #(
    parameter int unsigned       DATA_W = 64,
    parameter logic [DATA_W-1:0] BUBBLE = '0,
    parameter int unsigned       CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              up_valid,
    input  logic [DATA_W-1:0] up_payload,
    output logic              up_ready,
    output logic              down_valid,
    output logic [DATA_W-1:0] down_payload,
    input  logic              down_ready,
    input  logic              flush,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt,
    input  logic              stall_cnt_clr
);

    // The state encoding is the occupancy itself, so it can be exported as-is.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   main_q, main_d;   // head entry, drives down_payload
    logic [DATA_W-1:0]   skid_q, skid_d;   // second entry, filled only under backpressure
    logic                rdy_q, rdy_d;
    logic                dv_q, dv_d;
    logic [CNT_W-1:0]    stall_q, stall_d;

    logic                acc;
    logic                con;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        acc     = up_valid && rdy_q;
        con     = dv_q && down_ready;

        if (flush) begin
            // Transfers in the flush cycle are discarded, not merely delayed.
            state_d = EMPTY;
            main_d  = BUBBLE;
            skid_d  = BUBBLE;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (acc) begin
                        state_d = ONE;
                        main_d  = up_payload;
                    end
                end
                ONE: begin
                    if (acc && con) begin
                        main_d  = up_payload;
                    end else if (acc) begin
                        state_d = FULL;
                        skid_d  = up_payload;
                    end else if (con) begin
                        // Head leaves with nothing behind it: show a bubble.
                        state_d = EMPTY;
                        main_d  = BUBBLE;
                    end
                end
                FULL: begin
                    // up_ready is low here, so only the drain case exists.
                    if (con) begin
                        state_d = ONE;
                        main_d  = skid_q;
                        skid_d  = BUBBLE;
                    end
                end
                default: begin
                    state_d = EMPTY;
                    main_d  = BUBBLE;
                    skid_d  = BUBBLE;
                end
            endcase
        end

        // Flow-control outputs are computed from the next state and registered,
        // which keeps down_ready off any path to up_ready.
        rdy_d = (state_d != FULL);
        dv_d  = (state_d != EMPTY);
    end

    // -------------------------------------------------------------------------
    // Stall counter: counts the cycle just ending if the head was held.
    // -------------------------------------------------------------------------
    always_comb begin
        stall_d = stall_q;
        if (stall_cnt_clr) begin
            stall_d = '0;
        end else if (dv_q && !down_ready && (stall_q != CNT_MAX)) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            main_q  <= BUBBLE;
            skid_q  <= BUBBLE;
            rdy_q   <= 1'b1;
            dv_q    <= 1'b0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            rdy_q   <= rdy_d;
            dv_q    <= dv_d;
            stall_q <= stall_d;
        end
    end

    // main_q is kept at BUBBLE whenever the stage is empty, so it drives the
    // output directly.
    assign up_ready     = rdy_q;
    assign down_valid   = dv_q;
    assign down_payload = main_q;
    assign occupancy    = state_q;
    assign stall_cnt    = stall_q;

endmodule
